shift_reg_univ: RTL and testbench
=================================

SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2 to 64).
REQ-002 SHALL have parameter RST_VAL, default 0 (WIDTH bits), value loaded into q on reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-005 SHALL have port en  input  1  operation enable; when low, state holds.
REQ-006 SHALL have port mode  input  3  operation select, per REQ-012.
REQ-007 SHALL have port d  input  WIDTH  parallel load data.
REQ-008 SHALL have port sl_in  input  1  serial fill bit for shift left (enters bit 0).
REQ-009 SHALL have port sr_in  input  1  serial fill bit for shift right (enters bit WIDTH-1).
REQ-010 SHALL have port q  output  WIDTH  registered state.
REQ-011 SHALL have ports q1  output  WIDTH  bitwise complement of q (combinational); carry  output  1  registered shift-out/wrap flag; zero  output  1  combinational, high when q is all zeros.

Function
REQ-012 mode encoding SHALL be: 000 hold; 001 load d; 010 shift left; 011 shift right; 100 rotate left; 101 rotate right; 110 count up; 111 count down.
REQ-013 Every operation SHALL take effect on the rising edge where en=1 and rst=1, with q visible one cycle later (latency 1); no multi-cycle operations.
REQ-014 hold SHALL keep both q and carry unchanged.
REQ-015 load SHALL set q=d and carry=0.
REQ-016 shift left SHALL set q={q[WIDTH-2:0], sl_in} and carry=old q[WIDTH-1].
REQ-017 shift right SHALL set q={sr_in, q[WIDTH-1:1]} and carry=old q[0].
REQ-018 rotate left SHALL set q={q[WIDTH-2:0], q[WIDTH-1]}; rotate right SHALL set q={q[0], q[WIDTH-1:1]}. In both cases carry SHALL equal the bit that was rotated.
REQ-019 count up SHALL set q=q+1 modulo 2^WIDTH. carry SHALL be 1 only when old q was all ones (wrap), otherwise 0.
REQ-020 count down SHALL set q=q-1 modulo 2^WIDTH. carry SHALL be 1 only when old q was all zeros (borrow), otherwise 0.
REQ-021 When en=0, q and carry SHALL hold regardless of mode, d, sl_in and sr_in.
REQ-022 q1 and zero SHALL track q combinationally, with no added latency, including during and after reset.
REQ-023 d, sl_in and sr_in SHALL be ignored in every mode that does not use them.

Reset
REQ-024 On a rising edge with rst=0, the block SHALL set q=RST_VAL and carry=0, overriding en and mode (reset has highest priority).
REQ-025 Reset asserted mid-operation (for example during a count sequence) SHALL discard the pending operation that cycle. The first operation after reset SHALL be the first edge with rst=1 and en=1.
REQ-026 rst SHALL have no asynchronous effect: q SHALL not change between clock edges when rst changes.

Verification (WIDTH=8, RST_VAL=0)
REQ-027 Reset: rst=0 for one edge -> q=0x00, q1=0xFF, zero=1, carry=0; toggling rst between edges -> no change until the next edge.
REQ-028 Load then shift: mode=001, d=0xA5 -> q=0xA5, q1=0x5A. Then mode=010, sl_in=1 -> q=0x4B, carry=1. Then mode=011, sr_in=0 -> q=0x25, carry=1.
REQ-029 Rotate: load 0x01, then mode=101 -> q=0x80, carry=1. Then mode=100 -> q=0x01, carry=1.
REQ-030 Count wrap: load 0xFF, then mode=110 -> q=0x00, carry=1, zero=1. Then mode=111 -> q=0xFF, carry=1. Then mode=111 again -> q=0xFE, carry=0.
REQ-031 Enable/priority: en=0, mode=001, d=0x3C -> q and carry unchanged. rst=0, en=1, mode=001, d=0x3C -> q=0x00, carry=0.
REQ-032 Parameter sweep: repeat REQ-028 to REQ-030 with WIDTH=2 and WIDTH=32, and with RST_VAL=all ones -> all results match REQ-015 to REQ-020 scaled to WIDTH.

Source files
------------

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, parallel load, logical shifts with serial
// fill, rotates and up/down counting, all selected by a 3-bit mode and gated
// by a single enable. The carry flag captures the bit shifted or rotated out,
// or the wrap/borrow of the counter. The complement and zero-detect outputs
// are derived combinationally from the registered state.
module shift_reg_univ #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sl_in,
    input  logic             sr_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q1,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_INC  = 3'b110,
        OP_DEC  = 3'b111
    } op_t;

    op_t              op;
    logic [WIDTH-1:0] q_next;
    logic             carry_next;

    assign op = op_t'(mode);

    // Next-state selection; with en low or in hold, q and carry keep their values.
    always_comb begin
        q_next     = q;
        carry_next = carry;
        if (en) begin
            case (op)
                OP_HOLD: begin
                    q_next     = q;
                    carry_next = carry;
                end
                OP_LOAD: begin
                    q_next     = d;
                    carry_next = 1'b0;
                end
                OP_SHL: begin
                    q_next     = {q[WIDTH-2:0], sl_in};
                    carry_next = q[WIDTH-1];
                end
                OP_SHR: begin
                    q_next     = {sr_in, q[WIDTH-1:1]};
                    carry_next = q[0];
                end
                OP_ROL: begin
                    q_next     = {q[WIDTH-2:0], q[WIDTH-1]};
                    carry_next = q[WIDTH-1];
                end
                OP_ROR: begin
                    q_next     = {q[0], q[WIDTH-1:1]};
                    carry_next = q[0];
                end
                OP_INC: begin
                    q_next     = q + WIDTH'(1);
                    carry_next = &q;
                end
                OP_DEC: begin
                    q_next     = q - WIDTH'(1);
                    carry_next = ~|q;
                end
                default: begin
                    q_next     = q;
                    carry_next = carry;
                end
            endcase
        end
    end

    // State register; reset is synchronous and overrides any pending operation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q     <= RST_VAL;
            carry <= 1'b0;
        end else begin
            q     <= q_next;
            carry <= carry_next;
        end
    end

    assign q1   = ~q;
    assign zero = (q == '0);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: three instances (8-bit reset-to-zero, 2-bit and
// 32-bit reset-to-all-ones) share one stimulus stream. A driver pushes the
// reference model's expected state into per-instance queues; a monitor pops
// and compares one entry per clock edge after the outputs settle.
module tb_shift_reg_univ;

    localparam int NDUT = 3;

    typedef struct packed {
        logic [63:0] q;
        logic        c;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [2:0]  mode;
    logic [63:0] d_all;
    logic        sl_in;
    logic        sr_in;

    logic [7:0]  q_a, q1_a;
    logic [1:0]  q_b, q1_b;
    logic [31:0] q_c, q1_c;
    logic        carry_a, carry_b, carry_c;
    logic        zero_a, zero_b, zero_c;

    int unsigned      widths [NDUT] = '{8, 2, 32};
    longint unsigned  rst_vals [NDUT] = '{64'd0, 64'd3, 64'hFFFF_FFFF};
    longint unsigned  m_q [NDUT];
    bit               m_c [NDUT];

    exp_t sb0 [$];
    exp_t sb1 [$];
    exp_t sb2 [$];

    int n_checks = 0;
    int n_pass   = 0;

    shift_reg_univ #(.WIDTH(8), .RST_VAL(8'h00)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d_all[7:0]),
        .sl_in(sl_in), .sr_in(sr_in), .q(q_a), .q1(q1_a),
        .carry(carry_a), .zero(zero_a)
    );

    shift_reg_univ #(.WIDTH(2), .RST_VAL(2'b11)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d_all[1:0]),
        .sl_in(sl_in), .sr_in(sr_in), .q(q_b), .q1(q1_b),
        .carry(carry_b), .zero(zero_b)
    );

    shift_reg_univ #(.WIDTH(32), .RST_VAL(32'hFFFF_FFFF)) dut_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d_all[31:0]),
        .sl_in(sl_in), .sr_in(sr_in), .q(q_c), .q1(q1_c),
        .carry(carry_c), .zero(zero_c)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Behavioural model: treats the register as an unsigned number modulo
    // 2^W and applies each operation arithmetically.
    task automatic modelStep(input int idx, input bit r, input bit e,
                             input bit [2:0] m, input longint unsigned dd,
                             input bit sl, input bit sr);
        longint unsigned modv;
        longint unsigned half;
        longint unsigned cur;
        modv = 64'd1 << widths[idx];
        half = modv / 2;
        cur  = m_q[idx];
        if (!r) begin
            m_q[idx] = rst_vals[idx];
            m_c[idx] = 1'b0;
        end else if (e) begin
            case (m)
                3'd1: begin m_q[idx] = dd % modv; m_c[idx] = 1'b0; end
                3'd2: begin
                    m_c[idx] = (cur >= half);
                    m_q[idx] = (cur * 2 + (sl ? 1 : 0)) % modv;
                end
                3'd3: begin
                    m_c[idx] = (cur % 2) == 1;
                    m_q[idx] = cur / 2 + (sr ? half : 0);
                end
                3'd4: begin
                    m_c[idx] = (cur >= half);
                    m_q[idx] = (cur * 2 + (cur >= half ? 1 : 0)) % modv;
                end
                3'd5: begin
                    m_c[idx] = (cur % 2) == 1;
                    m_q[idx] = cur / 2 + ((cur % 2) == 1 ? half : 0);
                end
                3'd6: begin
                    m_c[idx] = (cur == modv - 1);
                    m_q[idx] = (cur + 1) % modv;
                end
                3'd7: begin
                    m_c[idx] = (cur == 0);
                    m_q[idx] = (cur + modv - 1) % modv;
                end
                default: begin end
            endcase
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue the expected result.
    task automatic applyStimulus(input bit r, input bit e, input bit [2:0] m,
                                 input logic [63:0] dd, input bit sl, input bit sr);
        @(negedge clk);
        rst   = r;
        en    = e;
        mode  = m;
        d_all = dd;
        sl_in = sl;
        sr_in = sr;
        for (int i = 0; i < NDUT; i++) modelStep(i, r, e, m, dd, sl, sr);
        sb0.push_back('{q: m_q[0], c: m_c[0]});
        sb1.push_back('{q: m_q[1], c: m_c[1]});
        sb2.push_back('{q: m_q[2], c: m_c[2]});
    endtask

    // Toggle rst between edges and confirm q does not move until the next edge.
    task automatic checkAsyncReset();
        @(negedge clk);
        en    = 1'b1;
        mode  = 3'b001;
        d_all = 64'h3C3C_3C3C;
        rst   = 1'b0;
        #2;
        checkOutput("async.w8.q", {56'd0, q_a}, m_q[0]);
        checkOutput("async.w32.q", {32'd0, q_c}, m_q[2]);
        rst = 1'b1;
        en  = 1'b0;
        #2;
        checkOutput("async.w8.q_rel", {56'd0, q_a}, m_q[0]);
        checkOutput("async.w2.q_rel", {62'd0, q_b}, m_q[1]);
        for (int i = 0; i < NDUT; i++) modelStep(i, 1'b1, 1'b0, mode, d_all, sl_in, sr_in);
        sb0.push_back('{q: m_q[0], c: m_c[0]});
        sb1.push_back('{q: m_q[1], c: m_c[1]});
        sb2.push_back('{q: m_q[2], c: m_c[2]});
    endtask

    // Compare all observable outputs of one instance against a popped entry.
    task automatic checkDut(input int idx, input exp_t e, input logic [63:0] aq,
                            input logic [63:0] aq1, input logic ac, input logic az);
        longint unsigned mask;
        string tag;
        mask = (64'd1 << widths[idx]) - 1;
        tag  = $sformatf("w%0d", widths[idx]);
        checkOutput({tag, ".q"}, aq, e.q);
        checkOutput({tag, ".q1"}, aq1, ~e.q & mask);
        checkOutput({tag, ".carry"}, {63'd0, ac}, {63'd0, e.c});
        checkOutput({tag, ".zero"}, {63'd0, az}, {63'd0, (e.q == 64'd0)});
    endtask

    // Monitor: one result per rising edge while expectations are outstanding.
    always @(posedge clk) begin
        #1;
        if (sb0.size() > 0 && sb1.size() > 0 && sb2.size() > 0) begin
            checkDut(0, sb0.pop_front(), {56'd0, q_a}, {56'd0, q1_a}, carry_a, zero_a);
            checkDut(1, sb1.pop_front(), {62'd0, q_b}, {62'd0, q1_b}, carry_b, zero_b);
            checkDut(2, sb2.pop_front(), {32'd0, q_c}, {32'd0, q1_c}, carry_c, zero_c);
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        mode  = 3'b000;
        d_all = '0;
        sl_in = 1'b0;
        sr_in = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            m_q[i] = 0;
            m_c[i] = 1'b0;
        end

        applyStimulus(1'b0, 1'b0, 3'b000, 64'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b110, 64'h0, 1'b0, 1'b0);
        checkAsyncReset();

        applyStimulus(1'b1, 1'b1, 3'b001, 64'hA5A5_A5A5, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b010, 64'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b011, 64'h0, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b1, 3'b001, 64'h1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b101, 64'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b100, 64'h0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b110, 64'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b111, 64'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b111, 64'h0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b0, 3'b001, 64'h3C3C_3C3C, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b000, 64'h3C3C_3C3C, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'b001, 64'h3C3C_3C3C, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 3'b110, 64'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b110, 64'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'b110, 64'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b111, 64'h0, 1'b0, 1'b0);

        for (int k = 0; k < 600; k++) begin
            applyStimulus(($urandom_range(0, 19) != 0),
                          ($urandom_range(0, 4) != 0),
                          3'($urandom_range(0, 7)),
                          {$urandom, $urandom},
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        @(negedge clk);
        checkOutput("sb.drained", 64'(sb0.size() + sb1.size() + sb2.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
